// File: rtl/elbeth_dual_port_memory_pkg.sv
// Shared definitions for elbeth_dual_port_memory: per-port FSM states,
// width constants and the read code on the byte-enable bus.
package elbeth_dual_port_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_t;

  localparam int          LANES   = 4;
  localparam int          CNT_W   = 4;
  localparam logic [3:0]  RW_READ = 4'b0000;

endpackage

// File: rtl/elbeth_memory_port_fsm.sv
// Per-port handshake FSM: captures the request, counts wait states, range-checks
// the captured address and pulses commit/ready for one access.
module elbeth_memory_port_fsm
  import elbeth_dual_port_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            rw,
  input  logic                  collide,
  output logic                  commit,
  output logic [ADDR_WIDTH-1:0] cap_addr,
  output logic [DATA_WIDTH-1:0] cap_wdata,
  output logic [3:0]            cap_rw,
  output logic                  in_range,
  output logic                  ready,
  output logic                  error
);

  port_state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic                  ready_r, ready_nxt_s;
  logic                  error_r, error_nxt_s;
  logic                  capture_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [3:0]            rw_r;

  // State, counter, captured request and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      ready_r <= 1'b0;
      error_r <= 1'b0;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      rw_r    <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= ready_nxt_s;
      error_r <= error_nxt_s;
      if (capture_s) begin
        addr_r  <= addr;
        wdata_r <= wdata;
        rw_r    <= rw;
      end else begin
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
        rw_r    <= rw_r;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (en) state_nxt_s = ST_WAIT; else state_nxt_s = ST_IDLE;
      ST_WAIT: if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = ST_RESP; else state_nxt_s = ST_WAIT;
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Commit strobe is gated by rst so an access aborted on its commit edge never writes.
  always_comb begin
    capture_s   = (state_r == ST_IDLE) && en;
    commit      = (state_r == ST_WAIT) && (cnt_r == {CNT_W{1'b0}}) && !rst;
    in_range    = (32'(addr_r) < 32'(DEPTH));
    cnt_nxt_s   = cnt_r;
    if (capture_s) begin
      cnt_nxt_s = CNT_W'(WAIT_STATES);
    end else if ((state_r == ST_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
    ready_nxt_s = commit;
    error_nxt_s = commit && (!in_range || collide);
  end

  assign cap_addr  = addr_r;
  assign cap_wdata = wdata_r;
  assign cap_rw    = rw_r;
  assign ready     = ready_r;
  assign error     = error_r;

endmodule

// File: rtl/elbeth_dual_port_memory.sv
// Dual-port byte-writable RAM responder with two independent handshake FSMs.
// Optional ELBETH_MEM_COLLISION_CHECK_EN turns same-word write collisions into errors.
module elbeth_dual_port_memory
  import elbeth_dual_port_memory_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 8,
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH       = 256,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [3:0]            a_rw,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_ready,
  output logic                  a_error,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [3:0]            b_rw,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_ready,
  output logic                  b_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_commit_s, b_commit_s, a_in_range_s, b_in_range_s;
  logic [ADDR_WIDTH-1:0] a_cap_addr_s, b_cap_addr_s;
  logic [DATA_WIDTH-1:0] a_cap_wdata_s, b_cap_wdata_s;
  logic [3:0]            a_cap_rw_s, b_cap_rw_s;
  logic [IDX_W-1:0]      a_idx_s, b_idx_s;
  logic                  collide_s, block_s;

  elbeth_memory_port_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .WAIT_STATES(WAIT_STATES)
  ) u_port_a (
    .clk(clk), .rst(rst), .en(a_en), .addr(a_addr), .wdata(a_wdata), .rw(a_rw),
    .collide(block_s), .commit(a_commit_s), .cap_addr(a_cap_addr_s),
    .cap_wdata(a_cap_wdata_s), .cap_rw(a_cap_rw_s), .in_range(a_in_range_s),
    .ready(a_ready), .error(a_error)
  );

  elbeth_memory_port_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .WAIT_STATES(WAIT_STATES)
  ) u_port_b (
    .clk(clk), .rst(rst), .en(b_en), .addr(b_addr), .wdata(b_wdata), .rw(b_rw),
    .collide(block_s), .commit(b_commit_s), .cap_addr(b_cap_addr_s),
    .cap_wdata(b_cap_wdata_s), .cap_rw(b_cap_rw_s), .in_range(b_in_range_s),
    .ready(b_ready), .error(b_error)
  );

  // Same in-range word committed on both ports with at least one writer.
  always_comb begin
    a_idx_s   = a_cap_addr_s[IDX_W-1:0];
    b_idx_s   = b_cap_addr_s[IDX_W-1:0];
    collide_s = a_commit_s && b_commit_s && a_in_range_s && b_in_range_s &&
                (a_cap_addr_s == b_cap_addr_s) &&
                ((a_cap_rw_s != RW_READ) || (b_cap_rw_s != RW_READ));
  end

`ifdef ELBETH_MEM_COLLISION_CHECK_EN
  assign block_s = collide_s;
`else
  assign block_s = 1'b0;
`endif

  // Byte-lane writes; port A is applied last so it wins overlapping lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (b_commit_s && b_in_range_s && !block_s && b_cap_rw_s[i])
        mem[b_idx_s][8*i +: 8] <= b_cap_wdata_s[8*i +: 8];
      if (a_commit_s && a_in_range_s && !block_s && a_cap_rw_s[i])
        mem[a_idx_s][8*i +: 8] <= a_cap_wdata_s[8*i +: 8];
    end
  end

  // Read data registers hold between read commits and clear on errored accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= {DATA_WIDTH{1'b0}};
      b_rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      if (a_commit_s && (!a_in_range_s || block_s)) a_rdata <= {DATA_WIDTH{1'b0}};
      else if (a_commit_s && (a_cap_rw_s == RW_READ)) a_rdata <= mem[a_idx_s];
      else a_rdata <= a_rdata;
      if (b_commit_s && (!b_in_range_s || block_s)) b_rdata <= {DATA_WIDTH{1'b0}};
      else if (b_commit_s && (b_cap_rw_s == RW_READ)) b_rdata <= mem[b_idx_s];
      else b_rdata <= b_rdata;
    end
  end

endmodule

// File: tb/tb_elbeth_dual_port_memory.sv
// Self-checking bench for elbeth_dual_port_memory (DEPTH=128, WAIT_STATES=1) against a
// word-array reference model; expectations follow ELBETH_MEM_COLLISION_CHECK_EN when defined.
module tb_elbeth_dual_port_memory;

  localparam int AW    = 8;
  localparam int DEPTH = 128;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, b_en;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [3:0]  a_rw, b_rw;
  logic        a_ready, b_ready, a_error, b_error;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  elbeth_dual_port_memory #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_addr(a_addr), .a_wdata(a_wdata), .a_rw(a_rw),
    .a_rdata(a_rdata), .a_ready(a_ready), .a_error(a_error),
    .b_en(b_en), .b_addr(b_addr), .b_wdata(b_wdata), .b_rw(b_rw),
    .b_rdata(b_rdata), .b_ready(b_ready), .b_error(b_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] rw);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (rw[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One aligned access on A and/or B, checked against the model, then the model is updated.
  task automatic pair(input string tag,
                      input bit ga, input logic [7:0] aa, input logic [31:0] awd, input logic [3:0] arw,
                      input bit gb, input logic [7:0] ba, input logic [31:0] bwd, input logic [3:0] brw);
    bit          ai, bi, col, blk;
    logic [31:0] ea_rd, eb_rd;
    logic        ea_er, eb_er;
    bit          a_seen, b_seen;
    int          a_lat, b_lat;
    logic [31:0] a_rd_o, b_rd_o;
    logic        a_er_o, b_er_o;
    a_seen = 1'b0; b_seen = 1'b0; a_lat = 0; b_lat = 0;
    a_rd_o = 32'h0; b_rd_o = 32'h0; a_er_o = 1'b0; b_er_o = 1'b0;
    ai  = int'(aa) < DEPTH;
    bi  = int'(ba) < DEPTH;
    col = ga && gb && ai && bi && (aa == ba) && ((arw != 4'h0) || (brw != 4'h0));
`ifdef ELBETH_MEM_COLLISION_CHECK_EN
    blk = col;
`else
    blk = 1'b0;
`endif
    ea_er = !ai || blk;
    eb_er = !bi || blk;
    ea_rd = ea_er ? 32'h0 : ((arw == 4'h0) ? mdl[aa[6:0]] : last_rd[0]);
    eb_rd = eb_er ? 32'h0 : ((brw == 4'h0) ? mdl[ba[6:0]] : last_rd[1]);

    @(negedge clk);
    a_en = ga; a_addr = aa; a_wdata = awd; a_rw = arw;
    b_en = gb; b_addr = ba; b_wdata = bwd; b_rw = brw;
    for (int n = 1; n <= 10 && !((a_seen || !ga) && (b_seen || !gb)); n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        a_addr = 8'($urandom); a_wdata = $urandom; a_rw = 4'($urandom);
        b_addr = 8'($urandom); b_wdata = $urandom; b_rw = 4'($urandom);
      end
      if (ga && !a_seen && a_ready) begin
        a_seen = 1'b1; a_lat = n; a_rd_o = a_rdata; a_er_o = a_error;
      end
      if (gb && !b_seen && b_ready) begin
        b_seen = 1'b1; b_lat = n; b_rd_o = b_rdata; b_er_o = b_error;
      end
    end
    if (ga) begin
      check({tag, ".a_lat"}, 32'(a_lat), 32'(WS + 2));
      check({tag, ".a_rdata"}, a_rd_o, ea_rd);
      check({tag, ".a_error"}, {31'd0, a_er_o}, {31'd0, ea_er});
    end
    if (gb) begin
      check({tag, ".b_lat"}, 32'(b_lat), 32'(WS + 2));
      check({tag, ".b_rdata"}, b_rd_o, eb_rd);
      check({tag, ".b_error"}, {31'd0, b_er_o}, {31'd0, eb_er});
    end
    @(negedge clk);
    a_en = 1'b0; b_en = 1'b0;
    @(posedge clk); #1;
    check({tag, ".pulse"}, {30'd0, a_ready, b_ready}, 32'h0);
    check({tag, ".err_clr"}, {30'd0, a_error, b_error}, 32'h0);
    if (ga) check({tag, ".a_hold"}, a_rdata, ea_rd);
    if (gb) check({tag, ".b_hold"}, b_rdata, eb_rd);

    if (gb && bi && !blk) mdl[ba[6:0]] = merge(mdl[ba[6:0]], bwd, brw);
    if (ga && ai && !blk) mdl[aa[6:0]] = merge(mdl[aa[6:0]], awd, arw);
    if (ga) last_rd[0] = ea_rd;
    if (gb) last_rd[1] = eb_rd;
  endtask

  initial begin
    logic [31:0] old;
    logic [7:0]  ra, rb;
    logic [3:0]  rwa, rwb;
    bit          ga, gb;
    rst = 1'b1;
    a_en = 1'b0; a_addr = 8'h0; a_wdata = 32'h0; a_rw = 4'h0;
    b_en = 1'b0; b_addr = 8'h0; b_wdata = 32'h0; b_rw = 4'h0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", {30'd0, a_ready, b_ready}, 32'h0);
    check("rst.error", {30'd0, a_error, b_error}, 32'h0);
    check("rst.a_rdata", a_rdata, 32'h0);
    check("rst.b_rdata", b_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < DEPTH / 2; i++)
      pair("init", 1'b1, 8'(i), $urandom, 4'hF, 1'b1, 8'(i + DEPTH / 2), $urandom, 4'hF);

    pair("t1.wr", 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 8'h0, 32'h0, 4'h0);
    pair("t1.rd", 1'b1, 8'h10, 32'h0, 4'h0, 1'b0, 8'h0, 32'h0, 4'h0);
    check("t1.value", a_rdata, 32'hDEADBEEF);

    pair("t2.pre", 1'b1, 8'h20, 32'h11223344, 4'hF, 1'b0, 8'h0, 32'h0, 4'h0);
    pair("t2.wr", 1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101);
    pair("t2.rd", 1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 8'h20, 32'h0, 4'h0);
    check("t2.value", b_rdata, 32'h11BB33DD);

    pair("t3.rd", 1'b1, 8'h80, 32'h0, 4'h0, 1'b0, 8'h0, 32'h0, 4'h0);
    pair("t3.wr", 1'b1, 8'h80, 32'hCAFEF00D, 4'hF, 1'b0, 8'h0, 32'h0, 4'h0);
    pair("t3.alias", 1'b1, 8'h00, 32'h0, 4'h0, 1'b0, 8'h0, 32'h0, 4'h0);

    pair("t4.col", 1'b1, 8'h05, 32'h01010101, 4'hF, 1'b1, 8'h05, 32'h02020202, 4'hF);
    pair("t4.rd", 1'b1, 8'h05, 32'h0, 4'h0, 1'b0, 8'h0, 32'h0, 4'h0);
    pair("t5.rdwr", 1'b1, 8'h05, 32'h0, 4'h0, 1'b1, 8'h05, 32'h0BADC0DE, 4'hF);
    pair("t5.rd", 1'b1, 8'h05, 32'h0, 4'h0, 1'b0, 8'h0, 32'h0, 4'h0);
    pair("lanes", 1'b1, 8'h06, 32'h11111111, 4'b0011, 1'b1, 8'h06, 32'h22222222, 4'b0110);
    pair("lanes.rd", 1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 8'h06, 32'h0, 4'h0);

    // Reset on the commit edge of an A write: the write must not land.
    old = mdl[8'h30];
    @(negedge clk);
    a_en = 1'b1; a_addr = 8'h30; a_wdata = ~old; a_rw = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; a_en = 1'b0;
    @(posedge clk); #1;
    check("t6.ready", {30'd0, a_ready, b_ready}, 32'h0);
    check("t6.error", {30'd0, a_error, b_error}, 32'h0);
    check("t6.rdata", a_rdata | b_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    pair("t6.rd", 1'b1, 8'h30, 32'h0, 4'h0, 1'b0, 8'h0, 32'h0, 4'h0);
    check("t6.value", a_rdata, old);

    for (int k = 0; k < 150; k++) begin
      ga  = ($urandom_range(0, 4) != 0);
      gb  = ($urandom_range(0, 4) != 0);
      ra  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 7));
      rwa = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rwb = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      pair("rand", ga, ra, $urandom, rwa, gb, rb, $urandom, rwb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
